// File: rtl/dmem_ctrl_pkg.sv
// dmem_ctrl_pkg: shared width defaults and FSM encodings for dmem_ctrl.
// ADDR_W_DEF matches the ALU's 7-bit word address. Defining DMEM_WBUF_EN adds the S_DRAIN encoding.
package dmem_ctrl_pkg;
  localparam int ADDR_W_DEF = 7;
  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF = 16;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
`ifdef DMEM_WBUF_EN
  localparam logic [1:0] S_DRAIN = 2'd3;
`endif
endpackage

// File: rtl/dmem_ctrl_wbuf.sv
// dmem_wbuf: one-entry posted write buffer for dmem_ctrl (used only when DMEM_WBUF_EN is defined).
// Ports: push/push_addr/push_data load the entry; lookup/hit compare an address against a valid entry;
// ack retires the entry; valid/addr/data expose the entry so it can drain to memory.
module dmem_wbuf
  import dmem_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic [ADDR_W-1:0] lookup,
  input  logic              ack,
  output logic              valid,
  output logic              hit,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);
  always_ff @(posedge clk)
    if (rst) begin
      valid <= 1'b0;
      addr <= '0;
      data <= '0;
    end else if (push) begin
      valid <= 1'b1;
      addr <= push_addr;
      data <= push_data;
    end else if (ack) begin
      valid <= 1'b0;
    end
  assign hit = valid && lookup == addr;
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory access controller between the ALU and an external req/ack memory.
// Ports: cpu_rd_i/cpu_wr_i/cpu_addr_i/cpu_wdata_i from the core, cpu_rdata_o load data and
// cpu_stall_o (holds PC, blocks RF write); mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o and
// mem_ack_i/mem_rdata_i to memory; stall_cnt_o saturating stalled-cycle count.
// Define DMEM_WBUF_EN for a one-entry posted write buffer with load forwarding.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_rd_i,
  input  logic              cpu_wr_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [CNT_W-1:0]  stall_cnt_o
);
  logic [1:0] state, state_next;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic lat_we, access, cap;
  logic [DATA_W-1:0] cap_data;
  assign access = cpu_rd_i | cpu_wr_i;
`ifdef DMEM_WBUF_EN
  logic bvalid, hit, post, fwd;
  logic [ADDR_W-1:0] baddr;
  logic [DATA_W-1:0] bdata;
  // a store is posted only into an empty buffer; a pure load hitting the buffer is forwarded
  assign post = cpu_wr_i & ~bvalid;
  assign fwd = cpu_rd_i & ~cpu_wr_i & hit;
  dmem_wbuf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wbuf (
    .clk(clk),
    .rst(rst),
    .push(state == S_IDLE && post),
    .push_addr(cpu_addr_i),
    .push_data(cpu_wdata_i),
    .lookup(cpu_addr_i),
    .ack(mem_ack_i),
    .valid(bvalid),
    .hit(hit),
    .addr(baddr),
    .data(bdata)
  );
  assign cpu_stall_o = (state == S_IDLE && access && !post) || state == S_REQ || state == S_DRAIN;
  // DRAIN waits for the buffer to empty, then one idle memory cycle before our own REQ
  always_comb
    state_next = state == S_IDLE ? (!access || post ? S_IDLE : fwd ? S_DONE : bvalid ? S_DRAIN : S_REQ) :
                 state == S_REQ ? (mem_ack_i ? S_DONE : S_REQ) :
                 state == S_DRAIN ? (bvalid ? S_DRAIN : S_REQ) : S_IDLE;
  // the buffer owns the memory port while valid; the FSM only issues REQ once it is empty
  assign mem_req_o = bvalid || state == S_REQ;
  assign mem_we_o = bvalid || lat_we;
  assign mem_addr_o = bvalid ? baddr : lat_addr;
  assign mem_wdata_o = bvalid ? bdata : lat_wdata;
  assign cap = (state == S_REQ && mem_ack_i && !lat_we) || (state == S_IDLE && fwd);
  assign cap_data = state == S_REQ ? mem_rdata_i : bdata;
`else
  assign cpu_stall_o = (state == S_IDLE && access) || state == S_REQ;
  always_comb
    state_next = state == S_IDLE ? (access ? S_REQ : S_IDLE) :
                 state == S_REQ ? (mem_ack_i ? S_DONE : S_REQ) : S_IDLE;
  assign mem_req_o = state == S_REQ;
  assign mem_we_o = lat_we;
  assign mem_addr_o = lat_addr;
  assign mem_wdata_o = lat_wdata;
  assign cap = state == S_REQ && mem_ack_i && !lat_we;
  assign cap_data = mem_rdata_i;
`endif
  always_ff @(posedge clk)
    if (rst) begin
      state <= S_IDLE;
      lat_addr <= '0;
      lat_wdata <= '0;
      lat_we <= 1'b0;
      cpu_rdata_o <= '0;
      stall_cnt_o <= '0;
    end else begin
      state <= state_next;
      if (state == S_IDLE && access) begin
        lat_addr <= cpu_addr_i;
        lat_wdata <= cpu_wdata_i;
        lat_we <= cpu_wr_i;
      end
      if (cap) cpu_rdata_o <= cap_data;
      if (cpu_stall_o && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end
endmodule
